// File: rtl/regfile_wport_arb.sv
// rtl/regfile_wport_arb.sv - two-requester register-file write-port arbiter with pending-write scoreboard
// Optional same-cycle bypass outputs are built when REGFILE_FWD_EN is defined.
module regfile_wport_arb #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_addr,
   input  logic [XLEN-1:0] a_data,
   input  logic            l_valid,
   output logic            l_ready,
   input  logic [AW-1:0]   l_addr,
   input  logic [XLEN-1:0] l_data,
   input  logic            claim_en,
   input  logic [AW-1:0]   claim_addr,
   input  logic [AW-1:0]   rd_addr1,
   input  logic [AW-1:0]   rd_addr2,
   output logic            stall,
   output logic            rf_wen,
   output logic [AW-1:0]   rf_addrW,
   output logic [XLEN-1:0] rf_dataW
`ifdef REGFILE_FWD_EN
   ,
   output logic            fwd1_hit,
   output logic [XLEN-1:0] fwd1_data,
   output logic            fwd2_hit,
   output logic [XLEN-1:0] fwd2_data
`endif
);

   localparam int NREG = 1 << AW;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            rr;
   logic            contend;
   logic            gnt_a;
   logic            gnt_l;
   logic            gnt;
   logic [AW-1:0]   g_addr;
   logic [XLEN-1:0] g_data;
   logic            pend1;
   logic            pend2;

   // rr names the requester that wins the next contended cycle (0 = ALU)
   always_comb begin
      gnt_a   = 1'b0;
      gnt_l   = 1'b0;
      contend = a_valid & l_valid;
      if (rst_n) begin
         if (contend) begin
            gnt_a = ~rr;
            gnt_l = rr;
         end else begin
            gnt_a = a_valid;
            gnt_l = l_valid;
         end
      end
   end

   assign gnt     = gnt_a | gnt_l;
   assign g_addr  = gnt_a ? a_addr : l_addr;
   assign g_data  = gnt_a ? a_data : l_data;
   assign a_ready = gnt_a;
   assign l_ready = gnt_l;

   // A claim is applied after the clear so a new producer stays outstanding
   always_comb begin
      busy_nxt = busy;
      if (gnt) begin
         busy_nxt[g_addr] = 1'b0;
      end
      if (claim_en) begin
         busy_nxt[claim_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= '0;
         rr       <= 1'b0;
         rf_wen   <= 1'b0;
         rf_addrW <= '0;
         rf_dataW <= '0;
      end else begin
         busy   <= busy_nxt;
         rf_wen <= gnt && (g_addr != '0);
         if (contend) begin
            rr <= ~rr;
         end
         if (gnt && (g_addr != '0)) begin
            rf_addrW <= g_addr;
            rf_dataW <= g_data;
         end
      end
   end

   assign pend1 = busy[rd_addr1] & (rd_addr1 != '0);
   assign pend2 = busy[rd_addr2] & (rd_addr2 != '0);

`ifdef REGFILE_FWD_EN
   logic hit1;
   logic hit2;

   assign hit1      = gnt & (rd_addr1 != '0) & (g_addr == rd_addr1);
   assign hit2      = gnt & (rd_addr2 != '0) & (g_addr == rd_addr2);
   assign fwd1_hit  = hit1;
   assign fwd2_hit  = hit2;
   assign fwd1_data = g_data;
   assign fwd2_data = g_data;
   assign stall     = (pend1 & ~hit1) | (pend2 & ~hit2);
`else
   assign stall     = pend1 | pend2;
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// tb/tb_regfile_wport_arb.sv - self-checking bench for regfile_wport_arb with a behavioural model
// Follows REGFILE_FWD_EN when it is defined for the build.
module tb_regfile_wport_arb;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NR   = 1 << AW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            a_valid = 1'b0, l_valid = 1'b0, claim_en = 1'b0;
   logic [AW-1:0]   a_addr = '0, l_addr = '0, claim_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
   logic [XLEN-1:0] a_data = '0, l_data = '0;
   logic            a_ready, l_ready, stall, rf_wen;
   logic [AW-1:0]   rf_addrW;
   logic [XLEN-1:0] rf_dataW;
`ifdef REGFILE_FWD_EN
   logic            fwd1_hit, fwd2_hit;
   logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

   regfile_wport_arb #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall(stall),
      .rf_wen(rf_wen), .rf_addrW(rf_addrW), .rf_dataW(rf_dataW)
`ifdef REGFILE_FWD_EN
      , .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
`endif
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference state
   bit              busy_m [NR];
   bit              rr_m = 1'b0;
   bit              ew = 1'b0;
   logic [AW-1:0]   ea = '0;
   logic [XLEN-1:0] ed = '0;
   bit              m_ga, m_gl, m_stall, m_h1, m_h2;
   logic [AW-1:0]   m_gaddr;
   logic [XLEN-1:0] m_gd;

   function automatic void model_comb();
      bit p1, p2;
      m_ga = 1'b0;
      m_gl = 1'b0;
      if (rst_n) begin
         if (a_valid && l_valid) begin
            if (rr_m) m_gl = 1'b1;
            else      m_ga = 1'b1;
         end else begin
            m_ga = a_valid;
            m_gl = l_valid;
         end
      end
      m_gaddr = m_ga ? a_addr : l_addr;
      m_gd    = m_ga ? a_data : l_data;
      m_h1 = (m_ga || m_gl) && rd_addr1 != 0 && m_gaddr == rd_addr1;
      m_h2 = (m_ga || m_gl) && rd_addr2 != 0 && m_gaddr == rd_addr2;
      p1 = rd_addr1 != 0 && busy_m[rd_addr1];
      p2 = rd_addr2 != 0 && busy_m[rd_addr2];
`ifdef REGFILE_FWD_EN
      if (m_h1) p1 = 1'b0;
      if (m_h2) p2 = 1'b0;
`endif
      m_stall = p1 || p2;
   endfunction

   function automatic void model_edge();
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) busy_m[i] = 1'b0;
         rr_m = 1'b0;
         ew = 1'b0;
         ea = '0;
         ed = '0;
      end else begin
         ew = (m_ga || m_gl) && m_gaddr != 0;
         if (ew) begin
            ea = m_gaddr;
            ed = m_gd;
            busy_m[m_gaddr] = 1'b0;
         end
         if (claim_en && claim_addr != 0) busy_m[claim_addr] = 1'b1;
         if (a_valid && l_valid) rr_m = !rr_m;
      end
   endfunction

   // apply the coming rising edge to the model, then wait for the following falling edge
   task automatic advance();
      model_comb();
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      a_valid = 0; l_valid = 0; claim_en = 0; rd_addr1 = 0; rd_addr2 = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; a_valid = 1; a_addr = 9; a_data = 32'hDEAD_BEEF;
      claim_en = 1; claim_addr = 4; rd_addr1 = 4;
      repeat (2) advance();
      #1;
      total_cnt++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got %b exp 0", a_ready); else pass_cnt++;
      total_cnt++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %b exp 0", rf_wen); else pass_cnt++;
      total_cnt++; if (rf_addrW !== '0 || rf_dataW !== '0)
         $display("FAIL reset_rf_addr_data got %0d/%h exp 0/0", rf_addrW, rf_dataW); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass_cnt++;
      idle_inputs();
      advance();
      rst_n = 1;
   endtask

   task automatic test_single_write();
      a_valid = 1; a_addr = 5; a_data = 32'h1234;
      #1;
      total_cnt++; if (a_ready !== 1'b1 || l_ready !== 1'b0)
         $display("FAIL single_ready got a=%b l=%b exp a=1 l=0", a_ready, l_ready); else pass_cnt++;
      advance();
      a_valid = 0;
      #1;
      total_cnt++; if (rf_wen !== 1'b1 || rf_addrW !== 5 || rf_dataW !== 32'h1234)
         $display("FAIL single_write got wen=%b a=%0d d=%h exp 1/5/1234", rf_wen, rf_addrW, rf_dataW); else pass_cnt++;
      advance();
      #1;
      total_cnt++; if (rf_wen !== 1'b0 || rf_addrW !== 5)
         $display("FAIL single_hold got wen=%b a=%0d exp 0/5", rf_wen, rf_addrW); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [AW-1:0] exp_a;
      a_valid = 1; l_valid = 1; a_addr = 1; l_addr = 2; a_data = 32'hA; l_data = 32'hB;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++; if (a_ready !== (i % 2 == 0) || l_ready !== (i % 2 == 1))
            $display("FAIL rr_grant%0d got a=%b l=%b exp a=%b", i, a_ready, l_ready, (i % 2 == 0)); else pass_cnt++;
         if (i > 0) begin
            exp_a = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
            total_cnt++; if (rf_addrW !== exp_a || rf_wen !== 1'b1)
               $display("FAIL rr_addr%0d got %0d exp %0d", i, rf_addrW, exp_a); else pass_cnt++;
         end
         advance();
      end
      idle_inputs();
      #1;
      total_cnt++; if (rf_addrW !== 2 || rf_dataW !== 32'hB)
         $display("FAIL rr_last got %0d/%h exp 2/b", rf_addrW, rf_dataW); else pass_cnt++;
      advance();
   endtask

   task automatic test_claim_stall();
      logic [XLEN-1:0] d;
      d = $urandom();
      claim_en = 1; claim_addr = 7;
      advance();
      claim_en = 0; rd_addr1 = 7;
      for (int i = 0; i < 2; i++) begin
         #1;
         total_cnt++; if (stall !== 1'b1) $display("FAIL claim_stall%0d got %b exp 1", i, stall); else pass_cnt++;
         advance();
      end
      l_valid = 1; l_addr = 7; l_data = d;
      #1;
`ifdef REGFILE_FWD_EN
      total_cnt++; if (stall !== 1'b0 || fwd1_hit !== 1'b1 || fwd1_data !== d)
         $display("FAIL fwd_grant got stall=%b hit=%b d=%h exp 0/1/%h", stall, fwd1_hit, fwd1_data, d); else pass_cnt++;
`else
      total_cnt++; if (stall !== 1'b1) $display("FAIL grant_cycle_stall got %b exp 1", stall); else pass_cnt++;
`endif
      total_cnt++; if (l_ready !== 1'b1) $display("FAIL claim_l_ready got %b exp 1", l_ready); else pass_cnt++;
      advance();
      l_valid = 0;
      #1;
      total_cnt++; if (stall !== 1'b0 || rf_wen !== 1'b1 || rf_addrW !== 7 || rf_dataW !== d)
         $display("FAIL after_grant got stall=%b wen=%b a=%0d d=%h exp 0/1/7/%h", stall, rf_wen, rf_addrW, rf_dataW, d); else pass_cnt++;
      idle_inputs();
      advance();
   endtask

   task automatic test_x0();
      l_valid = 1; l_addr = 0; l_data = 32'hFFFF_FFFF; claim_en = 1; claim_addr = 0;
      #1;
      total_cnt++; if (l_ready !== 1'b1) $display("FAIL x0_ready got %b exp 1", l_ready); else pass_cnt++;
      advance();
      idle_inputs();
      #1;
      total_cnt++; if (rf_wen !== 1'b0 || stall !== 1'b0)
         $display("FAIL x0_write got wen=%b stall=%b exp 0/0", rf_wen, stall); else pass_cnt++;
      advance();
   endtask

   task automatic test_claim_clear_same_edge();
      claim_en = 1; claim_addr = 3;
      advance();
      a_valid = 1; a_addr = 3; a_data = 32'h33; rd_addr2 = 3;
      #1;
      total_cnt++; if (a_ready !== 1'b1) $display("FAIL same_edge_ready got %b exp 1", a_ready); else pass_cnt++;
      advance();
      a_valid = 0; claim_en = 0;
      #1;
      total_cnt++; if (stall !== 1'b1) $display("FAIL same_edge_stall got %b exp 1", stall); else pass_cnt++;
      l_valid = 1; l_addr = 3;
      advance();
      idle_inputs();
      #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL same_edge_cleanup got %b exp 0", stall); else pass_cnt++;
   endtask

   task automatic test_reset_midflight();
      claim_en = 1; claim_addr = 9;
      advance();
      claim_en = 0; rst_n = 0; a_valid = 1; a_addr = 9; a_data = 32'h99; rd_addr1 = 9;
      #1;
      total_cnt++; if (a_ready !== 1'b0) $display("FAIL midreset_ready got %b exp 0", a_ready); else pass_cnt++;
      advance();
      rst_n = 1; a_valid = 0;
      #1;
      total_cnt++; if (rf_wen !== 1'b0 || stall !== 1'b0)
         $display("FAIL midreset_after got wen=%b stall=%b exp 0/0", rf_wen, stall); else pass_cnt++;
      idle_inputs();
      advance();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         if (!(a_valid && !m_ga)) begin
            a_valid = $urandom_range(0, 1);
            a_addr  = $urandom_range(0, 7);
            a_data  = $urandom();
         end
         if (!(l_valid && !m_gl)) begin
            l_valid = $urandom_range(0, 1);
            l_addr  = $urandom_range(0, 7);
            l_data  = $urandom();
         end
         claim_en   = ($urandom_range(0, 3) == 0);
         claim_addr = $urandom_range(0, 7);
         rd_addr1   = $urandom_range(0, 7);
         rd_addr2   = $urandom_range(0, 7);
         #1;
         model_comb();
         total_cnt++; if (a_ready !== m_ga || l_ready !== m_gl)
            $display("FAIL rand_ready c=%0d got a=%b l=%b exp a=%b l=%b", c, a_ready, l_ready, m_ga, m_gl); else pass_cnt++;
         total_cnt++; if (stall !== m_stall)
            $display("FAIL rand_stall c=%0d got %b exp %b", c, stall, m_stall); else pass_cnt++;
         total_cnt++; if (rf_wen !== ew || rf_addrW !== ea || rf_dataW !== ed)
            $display("FAIL rand_rf c=%0d got %b/%0d/%h exp %b/%0d/%h", c, rf_wen, rf_addrW, rf_dataW, ew, ea, ed); else pass_cnt++;
`ifdef REGFILE_FWD_EN
         total_cnt++; if (fwd1_hit !== m_h1 || fwd2_hit !== m_h2 || (m_h1 && fwd1_data !== m_gd) || (m_h2 && fwd2_data !== m_gd))
            $display("FAIL rand_fwd c=%0d got %b/%b exp %b/%b", c, fwd1_hit, fwd2_hit, m_h1, m_h2); else pass_cnt++;
`endif
         advance();
      end
      rst_n = 1;
      idle_inputs();
      advance();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_write();
      test_round_robin();
      test_claim_stall();
      test_x0();
      test_claim_clear_same_edge();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/regfile_wport_arb.md
REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 Parameter: XLEN, 32, data width of write port and forwarding paths.
REQ-002 Parameter: AW, 5, register address width (2**AW registers, x0 hardwired zero).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a_valid / a_ready / a_addr / a_data  in / out / in / in  1 / 1 / AW / XLEN  ALU writeback requester.
REQ-006 l_valid / l_ready / l_addr / l_data  in / out / in / in  1 / 1 / AW / XLEN  load-unit writeback requester.
REQ-007 claim_en / claim_addr  input  1 / AW  decode marks destination register as pending.
REQ-008 rd_addr1 / rd_addr2  input  AW  decode source register addresses.
REQ-009 stall  output  1  decode must hold: a source register is pending.
REQ-010 rf_wen / rf_addrW / rf_dataW  output  1 / AW / XLEN  registered drive of register-file write port.
REQ-011 fwd1_hit / fwd1_data / fwd2_hit / fwd2_data  output  1 / XLEN each  bypass for rd_addr1/rd_addr2; present only with REGFILE_FWD_EN.

Function
REQ-012 One write granted per cycle; a_ready / l_ready are combinational grants, high only when the matching valid is high.
REQ-013 Single valid requester granted; both valid: round-robin pointer rr selects (0 = ALU), rr toggles to the loser after each contended grant, unchanged otherwise.
REQ-014 Requester holds valid, addr, data stable until ready; transfer occurs on the edge where valid & ready.
REQ-015 Grant in cycle N -> rf_wen=1, rf_addrW/rf_dataW = granted addr/data during cycle N+1 only; no grant -> rf_wen=0, addr/data hold previous values.
REQ-016 Grant with addr=0: ready asserted, request consumed, rf_wen stays 0 in N+1, scoreboard untouched.
REQ-017 Scoreboard: busy[2**AW-1:0]; claim_en with claim_addr!=0 sets busy bit on the edge; granted write clears busy[addr] on the grant edge; busy[0] constantly 0.
REQ-018 Claim and grant-clear of same address on one edge: set wins (new producer outstanding).
REQ-019 Claim of an already-busy register: bit stays set; one outstanding write per register, no counting.
REQ-020 stall = (busy[rd_addr1] & rd_addr1!=0) | (busy[rd_addr2] & rd_addr2!=0), combinational, subject to REQ-024.
REQ-021 Read in cycle N+1 of a register written in N+1 needs no stall (write on falling edge precedes read on next rising edge).

Reset
REQ-022 rst_n=0 at rising edge: busy=0, rr=0, rf_wen=0, rf_addrW=0, rf_dataW=0; consequently stall=0.
REQ-023 While rst_n=0: a_ready=l_ready=0, claims ignored; requests in flight at reset assertion are dropped, never written.

Configuration
REQ-024 Macro REGFILE_FWD_EN defined: fwdK_hit = (rd_addrK!=0) & grant this cycle & granted addr==rd_addrK, fwdK_data = granted data; that source does not contribute to stall.
REQ-025 Macro REGFILE_FWD_EN undefined: fwd ports absent, stall strictly per REQ-020 (pending source stalls until cycle after grant).

Verification
REQ-026 Reset then a_valid=1,a_addr=5,a_data=0x1234 -> a_ready=1 same cycle; next cycle rf_wen=1,rf_addrW=5,rf_dataW=0x1234; following cycle rf_wen=0.
REQ-027 a_valid=l_valid=1 for 4 cycles with rr=0 -> grants ALU,LOAD,ALU,LOAD; rf_addrW sequence follows grants one cycle later.
REQ-028 claim 7, then rd_addr1=7 -> stall=1 until load writes x7; without REGFILE_FWD_EN stall drops cycle after grant; with it stall=0 and fwd1_hit=1,fwd1_data=load data in grant cycle.
REQ-029 l_addr=0,l_data=0xFFFF_FFFF granted -> l_ready=1, rf_wen stays 0; claim_addr=0 -> stall never asserted for rd_addr=0.
REQ-030 claim 3 and ALU grant to x3 on same edge -> busy[3]=1 after edge, stall=1 for rd_addr2=3.
REQ-031 busy[9]=1, a_valid=1 held, rst_n=0 one cycle -> a_ready=0, rf_wen=0, busy cleared, stall=0 after reset.
